// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use bubble, multi-cycle divide stall with watchdog, exception flush/redirect.
// Latency: stall/div_cancel are combinational in the request cycle; flush/new_pc appear the cycle after excp_req.
// Backpressure: drives the 6-bit stop bus to PC..WB; holds the IF instruction while ID is stopped.
// Optional PIPE_PERF_CNT_EN macro adds 32-bit load/divide stall-cycle counters (outputs tie to 0 without it).
module pipe_ctrl #(
    parameter int DIV_MAX = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_load,
    input  logic        div_start,
    input  logic        div_ready,
    input  logic        excp_req,
    input  logic [31:0] excp_pc,
    input  logic [31:0] inst_sram_rdata,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        div_cancel,
    output logic        div_timeout,
    output logic [31:0] inst_out,
    output logic [31:0] perf_load_stalls,
    output logic [31:0] perf_div_stalls
);

    // Stop-bus patterns: a load bubble freezes PC/IF/ID, a divide also freezes EX.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_LOAD = 6'b000111;
    localparam logic [5:0] STALL_DIV  = 6'b001111;

    // Watchdog limit in the width of the wait counter.
    localparam logic [5:0] WAIT_LIMIT = 6'(DIV_MAX);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DIV_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [5:0]  wait_cnt_q;
    logic [5:0]  wait_cnt_d;
    logic        wait_expired;
    logic        timeout_hit;
    logic [31:0] new_pc_q;
    logic        div_timeout_q;
    logic        hold_valid_q;
    logic [31:0] hold_inst_q;

    // The divider has been waited on for DIV_MAX cycles and still has no result.
    assign wait_expired = (state_q == ST_DIV_WAIT) && (wait_cnt_q == WAIT_LIMIT) && !div_ready;

    // State register; reset wins over any same-cycle exception.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: exception redirect beats everything, then divide entry/exit.
    always_comb begin
        state_d = state_q;
        if (excp_req) begin
            state_d = ST_FLUSH;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (div_start) begin
                        state_d = ST_DIV_WAIT;
                    end
                end
                ST_DIV_WAIT: begin
                    if (div_ready || wait_expired) begin
                        state_d = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Outputs: stop bus, flush strobe and divider abort, all forced quiet during reset.
    always_comb begin
        stall       = STALL_NONE;
        flush       = 1'b0;
        div_cancel  = 1'b0;
        timeout_hit = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ST_RUN: begin
                    // A divide request dominates a simultaneous load-use hazard.
                    if (div_start) begin
                        stall = STALL_DIV;
                    end else if (stallreq_load) begin
                        stall = STALL_LOAD;
                    end
                end
                ST_DIV_WAIT: begin
                    // Load hazards are irrelevant here: ID is already frozen by the divide.
                    // The pipe is released in the result cycle and in the watchdog-abort cycle.
                    if (!div_ready && !wait_expired) begin
                        stall = STALL_DIV;
                    end
                    div_cancel  = excp_req || wait_expired;
                    timeout_hit = wait_expired;
                end
                ST_FLUSH: begin
                    flush = 1'b1;
                end
                default: begin
                    stall = STALL_NONE;
                end
            endcase
        end
    end

    // Wait counter is zero in the first DIV_WAIT cycle and counts each cycle spent there.
    always_comb begin
        wait_cnt_d = 6'd0;
        if ((state_q == ST_DIV_WAIT) && (state_d == ST_DIV_WAIT)) begin
            wait_cnt_d = wait_cnt_q + 6'd1;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= 6'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Redirect target: captured on every exception request, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            new_pc_q <= 32'd0;
        end else if (excp_req) begin
            new_pc_q <= excp_pc;
        end
    end

    // Watchdog error flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_timeout_q <= 1'b0;
        end else if (timeout_hit) begin
            div_timeout_q <= 1'b1;
        end
    end

    // Capture the fetched word on the first ID-stop cycle so it survives the SRAM moving on.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_inst_q  <= 32'd0;
        end else if (flush || !stall[2]) begin
            hold_valid_q <= 1'b0;
        end else if (!hold_valid_q) begin
            hold_valid_q <= 1'b1;
            hold_inst_q  <= inst_sram_rdata;
        end
    end

    assign new_pc      = new_pc_q;
    assign div_timeout = div_timeout_q;
    assign inst_out    = hold_valid_q ? hold_inst_q : inst_sram_rdata;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_load_q;
    logic [31:0] perf_div_q;

    // Stall-cycle counters keyed on the exact stop-bus pattern; they wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_load_q <= 32'd0;
            perf_div_q  <= 32'd0;
        end else begin
            if (stall == STALL_LOAD) begin
                perf_load_q <= perf_load_q + 32'd1;
            end
            if (stall == STALL_DIV) begin
                perf_div_q <= perf_div_q + 32'd1;
            end
        end
    end

    assign perf_load_stalls = perf_load_q;
    assign perf_div_stalls  = perf_div_q;
`else
    assign perf_load_stalls = 32'd0;
    assign perf_div_stalls  = 32'd0;
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter DIV_MAX, 40, max cycles tolerated in DIV_WAIT before watchdog abort.
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 stallreq_load  in  1  ID load-use hazard (EX load targets ID rs/rt).
REQ-005 div_start  in  1  EX issues multi-cycle divide this cycle.
REQ-006 div_ready  in  1  divider result valid this cycle.
REQ-007 excp_req  in  1  exception/flush request.
REQ-008 excp_pc  in  32  redirect target for excp_req.
REQ-009 inst_sram_rdata  in  32  instruction word from inst SRAM.
REQ-010 stall  out  6  stop bus, bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop.
REQ-011 flush  out  1  one-cycle pipeline flush.
REQ-012 new_pc  out  32  redirect PC, valid while flush=1.
REQ-013 div_cancel  out  1  one-cycle divider abort pulse.
REQ-014 div_timeout  out  1  sticky watchdog error flag.
REQ-015 inst_out  out  32  instruction presented to ID (held or live).
REQ-016 perf_load_stalls, perf_div_stalls  out  32 each  stall-cycle counters.

Function
REQ-017 FSM states RUN, DIV_WAIT, FLUSH; encoding free.
REQ-018 RUN: div_start -> stall=6'b001111 same cycle (combinational), next state DIV_WAIT.
REQ-019 RUN: stallreq_load and not div_start -> stall=6'b000111 same cycle, state stays RUN (single bubble into EX).
REQ-020 RUN: neither request -> stall=6'b000000.
REQ-021 DIV_WAIT: stall=6'b001111 every cycle until div_ready=1; in div_ready cycle stall=6'b000000, next state RUN; stallreq_load ignored in DIV_WAIT.
REQ-022 DIV_WAIT: 6-bit wait counter cleared on entry, +1 per cycle; counter reaching DIV_MAX without div_ready -> div_cancel=1 one cycle, div_timeout set, next state RUN.
REQ-023 excp_req (any state, highest priority): next state FLUSH, new_pc <= excp_pc; if in DIV_WAIT also div_cancel=1 that cycle.
REQ-024 FLUSH: flush=1, stall=6'b000000 for exactly one cycle, next state RUN unless excp_req again (stay FLUSH, new_pc reloaded).
REQ-025 new_pc holds last captured value outside FLUSH.
REQ-026 Inst hold: on cycle where stall[2]=1 and hold_valid=0, hold_inst <= inst_sram_rdata, hold_valid <= 1.
REQ-027 hold_valid cleared on any cycle with stall[2]=0 or flush=1.
REQ-028 inst_out = hold_valid ? hold_inst : inst_sram_rdata (combinational mux).
REQ-029 Simultaneous div_start and stallreq_load: divide stall wins (6'b001111).
REQ-030 div_ready without DIV_WAIT: ignored.

Reset
REQ-031 rst: state RUN, stall=0, flush=0, new_pc=0, div_cancel=0, div_timeout=0, hold_valid=0, hold_inst=0, wait counter=0, perf counters=0.
REQ-032 rst mid-DIV_WAIT: return to RUN without div_cancel pulse.
REQ-033 rst overrides excp_req in same cycle.

Configuration
REQ-034 Macro PIPE_PERF_CNT_EN defined: perf_load_stalls +1 per cycle with stall=6'b000111, perf_div_stalls +1 per cycle with stall=6'b001111; both wrap 0xFFFFFFFF->0.
REQ-035 Macro undefined: no counter registers, both perf outputs constant 0.

Verification
REQ-036 stallreq_load one cycle in RUN -> stall=6'b000111 that cycle only, 6'b000000 next; perf_load_stalls=1 (PIPE_PERF_CNT_EN).
REQ-037 div_start, div_ready 33 cycles later -> stall=6'b001111 for 33 cycles, 0 in ready cycle; perf_div_stalls=33.
REQ-038 div_start, no div_ready, DIV_MAX=40 -> div_cancel pulse at wait count 40, div_timeout=1 sticky, state RUN.
REQ-039 excp_req with excp_pc=0xBFC00380 during DIV_WAIT -> div_cancel same cycle; next cycle flush=1, new_pc=0xBFC00380, stall=0; then RUN.
REQ-040 inst_sram_rdata=0x24020001 at load stall, then 0x00000000 -> inst_out=0x24020001 while stall[2]=1, live data after release.
